bus_arb_mux: RTL and testbench
==============================

BUS_ARB_MUX -- requirements
Module: bus_arb_mux

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, bits per channel word.
REQ-002 Parameter: DATA_NUM, default 4, number of upstream channels, legal range 2..16.
REQ-003 Local parameter CHAN_WIDTH SHALL equal clog2(DATA_NUM), with a minimum of 1.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 up_valid  input  DATA_NUM  per-channel beat valid.
REQ-007 up_ready  output  DATA_NUM  per-channel beat accept.
REQ-008 up_last  input  DATA_NUM  per-channel end-of-packet marker, qualified by up_valid.
REQ-009 up_data  input  DATA_WIDTH*DATA_NUM  flat bus; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 down_valid  output  1  registered output beat valid.
REQ-011 down_ready  input  1  downstream accept.
REQ-012 down_last  output  1  registered end-of-packet for the output beat.
REQ-013 down_data  output  DATA_WIDTH  registered output word.
REQ-014 down_chan  output  CHAN_WIDTH  index of the source channel of the output beat.

Function
REQ-015 Handshake: a beat transfers on any edge where valid and ready are both high, on either side; no combinational path from down_ready to up_ready is allowed other than the output-stage-free term defined in REQ-021.
REQ-016 Two states: IDLE (no grant) and LOCKED (grant held by one channel).
REQ-017 IDLE: if any up_valid is high, select the first valid channel searching from pointer ptr upward modulo DATA_NUM; register it as grant and move to LOCKED on the next edge.
REQ-018 IDLE with no up_valid high: remain in IDLE; grant and ptr unchanged.
REQ-019 up_ready SHALL be all-zero in IDLE.
REQ-020 A valid deassertion on the granted channel while LOCKED SHALL NOT release the grant; only an accepted beat with up_last high releases it.
REQ-021 LOCKED: up_ready[grant] = (!down_valid || down_ready); all other up_ready bits 0.
REQ-022 An accepted upstream beat SHALL load down_data, down_last and down_chan=grant and set down_valid on the same edge, giving one cycle of latency.
REQ-023 When down_valid && down_ready and no new beat is accepted on that edge, down_valid SHALL clear.
REQ-024 While down_valid && !down_ready, down_data, down_last and down_chan SHALL hold stable.
REQ-025 When the accepted beat carries up_last=1: state returns to IDLE and ptr becomes (grant+1) mod DATA_NUM.
REQ-026 Because of REQ-025, exactly one idle cycle (up_ready all 0) occurs between consecutive packets.
REQ-027 Single-beat packets (valid and last together) are legal and release the grant after that beat.
REQ-028 Sustained throughput within a packet SHALL be one beat per cycle when down_ready is held high.
REQ-029 ptr wrap: ptr = DATA_NUM-1 followed by a grant release SHALL produce ptr = 0.
REQ-030 up_data of non-granted channels SHALL have no effect on any output.

Reset
REQ-031 While rst_n=0, asynchronously: state=IDLE, ptr=0, grant=0, down_valid=0, down_last=0, down_data=0, down_chan=0, up_ready=0.
REQ-032 Reset asserted mid-packet SHALL discard the partial packet, including any pending output beat.
REQ-033 After rst_n rises, arbitration SHALL restart from channel 0.

Verification
REQ-034 Single packet: ch2 sends 3 beats A,B,C (last on C), down_ready=1 -> A,B,C appear on consecutive cycles, each one cycle after acceptance, down_chan=2, down_last only with C.
REQ-035 Fairness: all four channels continuously valid with single-beat packets -> down_chan sequence 0,1,2,3,0,1 with one idle cycle between beats.
REQ-036 Backpressure: down_ready held 0 for 3 cycles with a beat pending -> down_data/down_chan stable, up_ready[grant]=0; on down_ready=1 the pending beat is accepted and the next beat follows one cycle later.
REQ-037 Lock: ch1 mid-packet, ch0 raises valid -> ch0 up_ready stays 0 until ch1 last is accepted, then ch0 granted before ch1 is granted again (ptr=2 search wraps to 0).
REQ-038 Reset mid-packet: rst_n pulsed low during ch3 beat 2 -> all outputs 0 immediately; after release, with ch3 and ch0 both valid, ch0 is granted first.
REQ-039 Grant retention: ch2 granted, deasserts up_valid for 2 cycles mid-packet while ch1 is valid -> no ch1 beat transfers; ch2 resumes and completes its packet.

Source files
------------

// File: rtl/bus_arb_mux_if.sv
// Upstream/downstream signal bundle for bus_arb_mux. The slave view is the
// arbiter's own; the master view is whoever drives the upstream channels.
interface bus_arb_mux_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_NUM   = 4
);
  localparam int CHAN_WIDTH = ($clog2(DATA_NUM) < 1) ? 1 : $clog2(DATA_NUM);

  logic [DATA_NUM-1:0]            up_valid;
  logic [DATA_NUM-1:0]            up_ready;
  logic [DATA_NUM-1:0]            up_last;
  logic [DATA_WIDTH*DATA_NUM-1:0] up_data;
  logic                           down_valid;
  logic                           down_ready;
  logic                           down_last;
  logic [DATA_WIDTH-1:0]          down_data;
  logic [CHAN_WIDTH-1:0]          down_chan;

  modport master (
    output up_valid, up_last, up_data, down_ready,
    input  up_ready, down_valid, down_last, down_data, down_chan
  );

  modport slave (
    input  up_valid, up_last, up_data, down_ready,
    output up_ready, down_valid, down_last, down_data, down_chan
  );
endinterface

// File: rtl/bus_arb_mux.sv
// Packet-locked round-robin arbiter: merges DATA_NUM upstream streams into one
// registered downstream stream, holding each grant until a last beat is accepted.
module bus_arb_mux #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_NUM   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  bus_arb_mux_if.slave bus
);
  localparam int CHAN_WIDTH = ($clog2(DATA_NUM) < 1) ? 1 : $clog2(DATA_NUM);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [CHAN_WIDTH-1:0] grant_r;
  logic [CHAN_WIDTH-1:0] grant_nxt_s;
  logic [CHAN_WIDTH-1:0] ptr_r;
  logic [CHAN_WIDTH-1:0] ptr_nxt_s;
  logic [CHAN_WIDTH-1:0] pick_s;
  logic                  sel_valid_s;
  logic                  sel_last_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  out_free_s;
  logic                  accept_s;
  logic [DATA_NUM-1:0]   up_ready_s;
  logic                  down_valid_r;
  logic                  down_last_r;
  logic [DATA_WIDTH-1:0] down_data_r;
  logic [CHAN_WIDTH-1:0] down_chan_r;

  function automatic logic [CHAN_WIDTH-1:0] wrap_add(input logic [CHAN_WIDTH-1:0] base,
                                                     input int off);
    int sum;
    sum = int'(base) + off;
    sum = (sum >= DATA_NUM) ? (sum - DATA_NUM) : sum;
    return CHAN_WIDTH'(sum);
  endfunction

  // Round-robin pick: scan offsets high to low so the nearest valid channel at/after ptr wins.
  always_comb begin
    pick_s = ptr_r;
    for (int i = DATA_NUM - 1; i >= 0; i--) begin
      for (int k = 0; k < DATA_NUM; k++) begin
        pick_s = (bus.up_valid[k] && (wrap_add(ptr_r, i) == CHAN_WIDTH'(k))) ? CHAN_WIDTH'(k) : pick_s;
      end
    end
  end

  // Granted-channel mux; other channels' payloads never reach the outputs.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = '0;
    for (int k = 0; k < DATA_NUM; k++) begin
      sel_valid_s = (grant_r == CHAN_WIDTH'(k)) ? bus.up_valid[k] : sel_valid_s;
      sel_last_s  = (grant_r == CHAN_WIDTH'(k)) ? bus.up_last[k]  : sel_last_s;
      sel_data_s  = (grant_r == CHAN_WIDTH'(k)) ? bus.up_data[k*DATA_WIDTH +: DATA_WIDTH] : sel_data_s;
    end
  end

  assign out_free_s = !down_valid_r || bus.down_ready;
  assign accept_s   = (state_r == LOCKED) && sel_valid_s && out_free_s;

  // Only the granted channel may see ready, and only when the output stage can take a beat.
  always_comb begin
    up_ready_s = (state_r == LOCKED) ? (DATA_NUM'(out_free_s) << grant_r) : '0;
  end

  // Next-state logic: lock onto a channel from IDLE, release on an accepted last beat.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    ptr_nxt_s   = ptr_r;
    case (state_r)
      IDLE: begin
        if (|bus.up_valid) begin
          state_nxt_s = LOCKED;
          grant_nxt_s = pick_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCKED: begin
        if (accept_s && sel_last_s) begin
          state_nxt_s = IDLE;
          ptr_nxt_s   = wrap_add(grant_r, 32'sd1);
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Arbitration state, grant and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      grant_r <= '0;
      ptr_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      ptr_r   <= ptr_nxt_s;
    end
  end

  // Output stage: load on accept, drop valid once drained, otherwise hold the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      down_valid_r <= 1'b0;
      down_last_r  <= 1'b0;
      down_data_r  <= '0;
      down_chan_r  <= '0;
    end else if (accept_s) begin
      down_valid_r <= 1'b1;
      down_last_r  <= sel_last_s;
      down_data_r  <= sel_data_s;
      down_chan_r  <= grant_r;
    end else if (bus.down_ready) begin
      down_valid_r <= 1'b0;
    end else begin
      down_valid_r <= down_valid_r;
    end
  end

  assign bus.up_ready   = up_ready_s;
  assign bus.down_valid = down_valid_r;
  assign bus.down_last  = down_last_r;
  assign bus.down_data  = down_data_r;
  assign bus.down_chan  = down_chan_r;
endmodule

// File: tb/tb_bus_arb_mux.sv
// Randomized and directed bench for bus_arb_mux against a packet-level
// round-robin model (owner channel, pointer, one-deep output queue).
module tb_bus_arb_mux;
  localparam int DW = 16;
  localparam int N  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_arb_mux_if #(.DATA_WIDTH(DW), .DATA_NUM(N)) bus ();
  bus_arb_mux #(.DATA_WIDTH(DW), .DATA_NUM(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {logic [DW-1:0] data; logic last;} beat_t;
  typedef struct {logic [DW-1:0] data; logic last; int chan; int cyc;} obs_t;

  beat_t  src_q [N][$];
  bit [N-1:0] hold = '0;
  int     dr_pct = 100;
  obs_t   log_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;

  // model state
  int         m_owner = -1;
  int         m_rr    = 0;
  obs_t       m_out[$];
  logic [N-1:0] m_exp_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_pkt(input int ch, input int len, input logic [DW-1:0] base);
    for (int i = 0; i < len; i++) src_q[ch].push_back('{data: base + DW'(i), last: (i == len - 1)});
  endtask

  // One clock of upstream/downstream driving; pops beats that will transfer at the next edge.
  task automatic cycle(output bit popped);
    popped = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0 && !hold[k]) begin
        bus.up_valid[k]          = 1'b1;
        bus.up_data[k*DW +: DW]  = src_q[k][0].data;
        bus.up_last[k]           = src_q[k][0].last;
      end else begin
        bus.up_valid[k]          = 1'b0;
        bus.up_data[k*DW +: DW]  = DW'($urandom);
        bus.up_last[k]           = 1'($urandom);
      end
    end
    bus.down_ready = ($urandom_range(99) < dr_pct);
    #1;
    for (int k = 0; k < N; k++) begin
      if (bus.up_valid[k] && bus.up_ready[k]) begin
        void'(src_q[k].pop_front());
        popped = 1'b1;
      end
    end
  endtask

  task automatic drain(input int budget);
    bit p, done, empty;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      cycle(p);
      empty = 1'b1;
      for (int k = 0; k < N; k++) if (src_q[k].size() != 0) empty = 1'b0;
      if (empty && !p && !bus.down_valid) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_until_size(input int ch, input int sz);
    bit p;
    int i;
    for (i = 0; i < 50 && src_q[ch].size() > sz; i++) cycle(p);
    if (src_q[ch].size() > sz) check("wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_log(input int idx, input int chan, input logic [DW-1:0] data, input logic last);
    if (idx >= log_q.size()) begin
      check("log_missing", 32'(log_q.size()), 32'(idx + 1));
    end else begin
      check("log_chan", 32'(log_q[idx].chan), 32'(chan));
      check("log_data", 32'(log_q[idx].data), 32'(data));
      check("log_last", 32'(log_q[idx].last), 32'(last));
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_async", {bus.down_valid, bus.down_last, bus.down_chan, bus.up_ready, bus.down_data}, 32'd0);
    for (int k = 0; k < N; k++) src_q[k].delete();
    bus.up_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
  endtask

  // Per-cycle comparison against the packet-level model, then advance it over the next edge.
  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      m_owner = -1;
      m_rr    = 0;
      m_out.delete();
      check("rst_outs", {bus.down_valid, bus.down_last, bus.down_chan, bus.up_ready, bus.down_data}, 32'd0);
    end else begin
      m_exp_ready = '0;
      if (m_owner >= 0 && (m_out.size() == 0 || bus.down_ready)) m_exp_ready[m_owner] = 1'b1;
      check("up_ready", 32'(bus.up_ready), 32'(m_exp_ready));
      check("down_valid", 32'(bus.down_valid), 32'(m_out.size() != 0));
      if (m_out.size() != 0) begin
        check("down_data", 32'(bus.down_data), 32'(m_out[0].data));
        check("down_last", 32'(bus.down_last), 32'(m_out[0].last));
        check("down_chan", 32'(bus.down_chan), 32'(m_out[0].chan));
        if (bus.down_ready) begin
          log_q.push_back('{data: bus.down_data, last: bus.down_last, chan: int'(bus.down_chan), cyc: cyc});
          void'(m_out.pop_front());
        end
      end
      if (m_owner >= 0 && bus.up_valid[m_owner] && m_exp_ready[m_owner]) begin
        m_out.push_back('{data: bus.up_data[m_owner*DW +: DW], last: bus.up_last[m_owner], chan: m_owner, cyc: 0});
        if (bus.up_last[m_owner]) begin
          m_rr    = (m_owner + 1) % N;
          m_owner = -1;
        end
      end else if (m_owner < 0 && bus.up_valid != '0) begin
        for (int i = 0; i < N; i++) begin
          if (bus.up_valid[(m_rr + i) % N]) begin
            m_owner = (m_rr + i) % N;
            break;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    check("watchdog", 32'd0, 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    bit p;
    bus.up_valid = '0;
    bus.up_last  = '0;
    bus.up_data  = '0;
    bus.down_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // single 3-beat packet on ch2
    log_q.delete();
    push_pkt(2, 3, 16'h00A1);
    drain(40);
    check("pkt_len", 32'(log_q.size()), 32'd3);
    check_log(0, 2, 16'h00A1, 1'b0);
    check_log(1, 2, 16'h00A2, 1'b0);
    check_log(2, 2, 16'h00A3, 1'b1);
    if (log_q.size() == 3) begin
      check("pkt_back2back_1", 32'(log_q[1].cyc - log_q[0].cyc), 32'd1);
      check("pkt_back2back_2", 32'(log_q[2].cyc - log_q[1].cyc), 32'd1);
    end

    // reset during ch3 beat 2, then ch0 must win over ch3
    push_pkt(3, 4, 16'h3300);
    run_until_size(3, 2);
    reset_pulse();
    push_pkt(3, 1, 16'h0333);
    push_pkt(0, 1, 16'h0F00);
    drain(40);
    check("rst_len", 32'(log_q.size()), 32'd2);
    check_log(0, 0, 16'h0F00, 1'b1);
    check_log(1, 3, 16'h0333, 1'b1);

    // fairness: single-beat packets on every channel, ptr starts at 0
    log_q.delete();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) push_pkt(k, 1, DW'(16'h0100 * k + r));
    drain(80);
    check("fair_len", 32'(log_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      check("fair_chan", 32'(log_q[i].chan), 32'(i % 4));
      if (i > 0) check("fair_gap", 32'(log_q[i].cyc - log_q[i-1].cyc), 32'd2);
    end

    // backpressure on ch1
    log_q.delete();
    dr_pct = 0;
    push_pkt(1, 2, 16'h1111);
    for (int i = 0; i < 10 && !bus.down_valid; i++) cycle(p);
    for (int i = 0; i < 3; i++) begin
      cycle(p);
      check("bp_ready", 32'(bus.up_ready), 32'd0);
      check("bp_data", 32'(bus.down_data), 32'h1111);
      check("bp_chan", 32'(bus.down_chan), 32'd1);
    end
    dr_pct = 100;
    cycle(p);
    check("bp_release_ready", 32'(bus.up_ready), 32'b0010);
    cycle(p);
    check("bp_next_data", 32'(bus.down_data), 32'h1112);
    check("bp_next_last", 32'(bus.down_last), 32'd1);
    drain(20);

    // lock: ch1 mid-packet, ch0 arrives; ptr=2 search wraps to ch0 before ch1 again
    log_q.delete();
    push_pkt(1, 3, 16'h1A01);
    push_pkt(1, 1, 16'h1B01);
    run_until_size(1, 3);
    push_pkt(0, 1, 16'h0C01);
    drain(60);
    check("lock_len", 32'(log_q.size()), 32'd5);
    check_log(0, 1, 16'h1A01, 1'b0);
    check_log(2, 1, 16'h1A03, 1'b1);
    check_log(3, 0, 16'h0C01, 1'b1);
    check_log(4, 1, 16'h1B01, 1'b1);

    // grant retention: ch2 drops valid mid-packet while ch1 waits
    log_q.delete();
    push_pkt(2, 3, 16'h2C01);
    run_until_size(2, 2);
    hold[2] = 1'b1;
    push_pkt(1, 1, 16'h1D01);
    for (int i = 0; i < 2; i++) begin
      cycle(p);
      check("hold_ch1_ready", 32'(bus.up_ready[1]), 32'd0);
    end
    hold = '0;
    drain(60);
    check("hold_len", 32'(log_q.size()), 32'd4);
    check_log(2, 2, 16'h2C03, 1'b1);
    check_log(3, 1, 16'h1D01, 1'b1);

    // randomized traffic with valid gaps and backpressure
    dr_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) begin
        int ch;
        ch = int'($urandom_range(N - 1));
        if (src_q[ch].size() < 8) push_pkt(ch, int'($urandom_range(4, 1)), DW'($urandom));
      end
      hold = N'($urandom) & N'($urandom);
      cycle(p);
    end
    hold = '0;
    dr_pct = 100;
    drain(500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
